everloop_framebuf: RTL and testbench



---
 rtl/everloop_framebuf_if.sv | 34 +++
 rtl/everloop_framebuf.sv | 122 ++++++++++++
 tb/tb_everloop_framebuf.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/everloop_framebuf_if.sv
// Bus between the everloop frame buffer and its two clients: the LED
// serialiser (byte reads) and the host (writes, commit).
//
// Handshake: a host write transfers on a rising clock edge where wr_en=1 and
// wr_ready=1; wr_en with wr_ready=0 is ignored, and nothing is queued.
// commit is a one-cycle request. swap_done is a one-cycle pulse when the banks
// swap. state_dbg exposes the controller state (0 = FILL, 1 = PEND).
interface everloop_framebuf_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] address;
    logic [7:0]        data_RGB;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ready;
    logic              commit;
    logic              swap_done;
    logic              front_sel;
    logic [7:0]        frame_cnt;
    logic              state_dbg;

    // Client side: serialiser and host
    modport master (
        output address, wr_en, wr_addr, wr_data, commit,
        input  data_RGB, wr_ready, swap_done, front_sel, frame_cnt, state_dbg
    );

    // Frame buffer side
    modport slave (
        input  address, wr_en, wr_addr, wr_data, commit,
        output data_RGB, wr_ready, swap_done, front_sel, frame_cnt, state_dbg
    );
endinterface

// File: rtl/everloop_framebuf.sv
// Double-buffered frame store feeding the everloop LED serialiser.
// The serialiser reads bytes from the front bank; the host fills the back
// bank and commits it. The banks swap only at a frame start (read address
// returning to 0), so the LED chain never shows a torn frame.
// Optional feature macro: EVERLOOP_BRIGHTNESS_EN adds a brightness input and
// scales each read byte by (brightness+1)/256.
module everloop_framebuf #(
    parameter int FRAME_BYTES = 141,
    parameter int ADDR_W      = 8
) (
    input  logic clk,
    input  logic rst,
`ifdef EVERLOOP_BRIGHTNESS_EN
    input  logic [7:0] brightness,
`endif
    everloop_framebuf_if.slave bus
);

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] FRAME_LIM = ADDR_W'(FRAME_BYTES);

    // Bank contents come up zero at configuration and survive rst.
    logic [7:0] bank_mem [2][FRAME_BYTES] = '{default: '0};

    state_t            state_q, state_d;
    logic              front_sel_q, front_sel_d;
    logic              swap_done_q, swap_done_d;
    logic [7:0]        frame_cnt_q;
    logic [ADDR_W-1:0] addr_prev_q;
    logic [7:0]        data_q, data_d;
    logic              wr_ready;
    logic              frame_start;
    logic              wr_fire;
    logic [7:0]        raw_byte;

    assign frame_start = (bus.address == '0) && (addr_prev_q != '0);
    assign wr_fire     = bus.wr_en && wr_ready && (bus.wr_addr < FRAME_LIM);

    // Controller: FILL accepts writes until commit, PEND waits for a frame start to swap
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_done_d = 1'b0;
        wr_ready    = 1'b0;
        case (state_q)
            FILL: begin
                wr_ready = 1'b1;
                if (bus.commit) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (frame_start) begin
                    front_sel_d = ~front_sel_q;
                    swap_done_d = 1'b1;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Read mux: front_sel_d already points at the new bank on the swapping
    // frame start, so byte 0 of the new frame comes from the new bank too.
    always_comb begin
        raw_byte = 8'h00;
        if (bus.address < FRAME_LIM) begin
            raw_byte = bank_mem[front_sel_d][bus.address];
        end
    end

`ifdef EVERLOOP_BRIGHTNESS_EN
    logic [15:0] scaled;
    // Brightness scaling: 255 passes bytes unchanged, 0 blanks them
    always_comb begin
        scaled = 16'(raw_byte) * (16'(brightness) + 16'd1);
        data_d = 8'(scaled >> 8);
    end
`else
    assign data_d = raw_byte;
`endif

    // Host writes land in the back bank only
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_mem[~front_sel_q][bus.wr_addr] <= bus.wr_data;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            front_sel_q <= 1'b0;
            swap_done_q <= 1'b0;
            frame_cnt_q <= 8'h00;
            addr_prev_q <= '0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_done_q <= swap_done_d;
            addr_prev_q <= bus.address;
            data_q      <= data_d;
            if (frame_start) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign bus.data_RGB  = data_q;
    assign bus.wr_ready  = wr_ready;
    assign bus.swap_done = swap_done_q;
    assign bus.front_sel = front_sel_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.state_dbg = logic'(state_q);

endmodule

// File: tb/tb_everloop_framebuf.sv
// Directed bench for everloop_framebuf: bank model plus expected-read queue.
module tb_everloop_framebuf;

    logic clk;
    logic rst;
`ifdef EVERLOOP_BRIGHTNESS_EN
    logic [7:0] brightness;
`endif

    everloop_framebuf_if #(.ADDR_W(8)) bus ();

    everloop_framebuf #(.FRAME_BYTES(141), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef EVERLOOP_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .bus        (bus.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench state
    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    int         swap_seen = 0;
    int         m_front = 0;
    logic [7:0] m_mem [2][141];
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        if (bus.swap_done === 1'b1) swap_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a read address, push the expected byte, pop and compare after the edge
    task automatic rd(input int a);
        logic [7:0]  raw;
        logic [15:0] sc;
        logic [7:0]  got;
        raw = (a < 141) ? m_mem[m_front][a] : 8'h00;
`ifdef EVERLOOP_BRIGHTNESS_EN
        sc  = 16'(raw) * (16'(brightness) + 16'd1);
        raw = 8'(sc >> 8);
`else
        sc  = 16'(raw);
`endif
        bus.address = a[7:0];
        exp_q.push_back(raw);
        step();
        got = exp_q.pop_front();
        chk($sformatf("rd_%0d", a), bus.data_RGB, got);
    endtask

    // One host write cycle; accept says whether the bench expects it to land
    task automatic wr(input int a, input logic [7:0] d, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[7:0];
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        if (accept && a < 141) m_mem[1 - m_front][a] = d;
    endtask

    initial begin
        rst         = 1'b1;
        bus.address = 8'd0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 8'd0;
        bus.wr_data = 8'd0;
        bus.commit  = 1'b0;
`ifdef EVERLOOP_BRIGHTNESS_EN
        brightness  = 8'd255;
`endif
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 141; i++)
                m_mem[b][i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",      bus.data_RGB,  0);
        chk("rst_wr_ready",  bus.wr_ready,  1);
        chk("rst_swap_done", bus.swap_done, 0);
        chk("rst_front_sel", bus.front_sel, 0);
        chk("rst_frame_cnt", bus.frame_cnt, 0);
        chk("rst_state",     bus.state_dbg, 0);
        rst = 1'b0;

        // Plain read out of reset, no frame start
        rd(5);
        chk("r5_front_sel", bus.front_sel, 0);
        chk("r5_wr_ready",  bus.wr_ready,  1);
        chk("r5_frame_cnt", bus.frame_cnt, 0);

        // Fill back bank 1; out-of-range writes dropped; write + commit together
        wr(3, 8'hA5, 1);
        wr(0, 8'h5A, 1);
        wr(141, 8'hEE, 0);
        wr(200, 8'hEE, 0);
        bus.commit = 1'b1;
        wr(7, 8'h77, 1);
        bus.commit = 1'b0;
        chk("pend_wr_ready", bus.wr_ready,  0);
        chk("pend_state",    bus.state_dbg, 1);
        wr(3, 8'h11, 0);
        chk("pend_no_swap", swap_seen, 0);

        // Sweep a frame from the old front bank, then wrap to 0
        for (int a = 1; a < 141; a++) rd(a);
        chk("sweep_no_swap", swap_seen, 0);
        m_front = 1;
        rd(0);
        chk("swap1_pulse",     bus.swap_done, 1);
        chk("swap1_front_sel", bus.front_sel, 1);
        chk("swap1_frame_cnt", bus.frame_cnt, 1);
        chk("swap1_wr_ready",  bus.wr_ready,  1);
        chk("swap1_state",     bus.state_dbg, 0);
        rd(0);
        chk("swap1_pulse_end", bus.swap_done, 0);
        chk("swap1_count",     swap_seen,     1);
        rd(3);
        rd(7);
        rd(141);
        rd(200);

        // Commit on the frame-start cycle: swap deferred to the next frame
        wr(0, 8'h3C, 1);
        bus.commit = 1'b1;
        rd(0);
        bus.commit = 1'b0;
        chk("late_frame_cnt", bus.frame_cnt, 2);
        chk("late_front_sel", bus.front_sel, 1);
        chk("late_state",     bus.state_dbg, 1);
        chk("late_no_pulse",  bus.swap_done, 0);
        rd(10);
        m_front = 0;
        rd(0);
        chk("swap2_pulse",     bus.swap_done, 1);
        chk("swap2_front_sel", bus.front_sel, 0);
        chk("swap2_frame_cnt", bus.frame_cnt, 3);
        rd(3);
        chk("swap2_count", swap_seen, 2);

        // Third swap, then reset in the middle of PEND
        wr(3, 8'h22, 1);
        bus.commit = 1'b1;
        rd(5);
        bus.commit = 1'b0;
        m_front = 1;
        rd(0);
        chk("swap3_front_sel", bus.front_sel, 1);
        chk("swap3_frame_cnt", bus.frame_cnt, 4);
        rd(3);
        bus.commit = 1'b1;
        rd(8);
        bus.commit = 1'b0;
        chk("pend2_state", bus.state_dbg, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_state",     bus.state_dbg, 0);
        chk("mid_rst_front_sel", bus.front_sel, 0);
        chk("mid_rst_wr_ready",  bus.wr_ready,  1);
        chk("mid_rst_swap_done", bus.swap_done, 0);
        chk("mid_rst_frame_cnt", bus.frame_cnt, 0);
        step();
        rst = 1'b0;
        m_front = 0;
        rd(3);
        rd(0);
        chk("post_rst_no_pulse", bus.swap_done, 0);
        chk("post_rst_front",    bus.front_sel, 0);
        chk("post_rst_cnt",      bus.frame_cnt, 1);
        rd(5);
        chk("post_rst_swaps", swap_seen, 3);

`ifdef EVERLOOP_BRIGHTNESS_EN
        // Brightness scaling on a byte of 0x80
        wr(9, 8'h80, 1);
        bus.commit = 1'b1;
        rd(6);
        bus.commit = 1'b0;
        m_front = 1;
        rd(0);
        brightness = 8'd127;
        rd(9);
        chk("bright_127", bus.data_RGB, 8'h40);
        brightness = 8'd255;
        rd(9);
        chk("bright_255", bus.data_RGB, 8'h80);
        brightness = 8'd0;
        rd(9);
        chk("bright_0", bus.data_RGB, 8'h00);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
